// File: rtl/dac_serial_tx_pkg.sv
// Shared definitions for the dual-channel DAC serial transmitter:
// register map, CTRL/STAT bit positions and FSM state encoding.
package dac_serial_tx_pkg;

  localparam logic [3:0] ADDR_CHA_LO = 4'h0;
  localparam logic [3:0] ADDR_CHA_HI = 4'h1;
  localparam logic [3:0] ADDR_CHB_LO = 4'h2;
  localparam logic [3:0] ADDR_CHB_HI = 4'h3;
  localparam logic [3:0] ADDR_DIV    = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h5;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_IE_BIT    = 1;
  localparam int unsigned CTRL_CLR_BIT   = 7;

  localparam logic [7:0] RD_UNMAPPED = 8'hAA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  // CTRL/STAT read layout: {DONE, 5'b0, IE, BUSY}
  function automatic logic [7:0] status_byte(input logic done, input logic ie, input logic busy);
    return {done, 5'b0_0000, ie, busy};
  endfunction

endpackage

// File: rtl/dac_serial_tx_tick_gen.sv
// Phase timer for the DAC serial clock: a down-counter that emits a
// one-cycle tick every div_i+1 clocks while enabled. load_i restarts the
// count from div_i.
module dac_serial_tx_tick_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Next count and tick: reload on load or on expiry, otherwise count down
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = en_i && !load_i && (cnt_q == '0);
    if (load_i) begin
      cnt_d = div_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? div_i : cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dac_serial_tx.sv
// Bus-mapped serial transmitter for the external dual-channel DAC.
// The CPU loads two channel codes and a divider, then writes START; both
// channels are shifted MSB-first in parallel on dac_dat0/dac_dat1 with
// dac_clk, followed by one dac_le pulse. Each clock level lasts DIV+1 clocks.
// Optional build macro: DAC_IRQ_EN adds the irq port and the IE control bit.
module dac_serial_tx
  import dac_serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DIV_W = 8
) (
  input  logic       wb_clk_i,
  input  logic       rst,
  input  logic [3:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       bus_cyc,
  input  logic       bus_we,
  output logic       dac_clk,
  output logic       dac_le,
  output logic       dac_dat0,
  output logic       dac_dat1
`ifdef DAC_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  cha_q, cha_d, chb_q, chb_d;
  logic [WIDTH-1:0]  sha_q, sha_d, shb_q, shb_d;
  logic [DIV_W-1:0]  div_q, div_d, div_snap_q, div_snap_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              done_q, done_d;
  logic              ie_q, ie_d;
  logic [7:0]        data_out_q, data_out_d;

  logic              wr, wr_ctrl, start_acc, busy, tick, frame_end;
  logic [DIV_W-1:0]  tick_div;
  logic [15:0]       cha_ext, chb_ext;
  logic [7:0]        rd_data;

  assign wr        = bus_cyc & bus_we;
  assign wr_ctrl   = wr && (addr == ADDR_CTRL);
  assign busy      = (state_q != ST_IDLE);
  assign start_acc = wr_ctrl && data_in[CTRL_START_BIT] && !busy;
  assign frame_end = (state_q == ST_LATCH) && tick;

  // At START the live divider seeds the timer; afterwards the frame snapshot
  // is used so DIV writes mid-frame do not disturb the current frame.
  assign tick_div  = start_acc ? div_q : div_snap_q;

  dac_serial_tx_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk_i  (wb_clk_i),
    .rst_i  (rst),
    .en_i   (busy),
    .load_i (start_acc),
    .div_i  (tick_div),
    .tick_o (tick)
  );

  // Holding registers and DONE/IE control; a frame completing wins over a clear
  always_comb begin
    cha_d  = cha_q;
    chb_d  = chb_q;
    div_d  = div_q;
    ie_d   = ie_q;
    done_d = done_q;
    if (wr) begin
      case (addr)
        ADDR_CHA_LO: cha_d[7:0]       = data_in;
        ADDR_CHA_HI: cha_d[WIDTH-1:8] = data_in[WIDTH-9:0];
        ADDR_CHB_LO: chb_d[7:0]       = data_in;
        ADDR_CHB_HI: chb_d[WIDTH-1:8] = data_in[WIDTH-9:0];
        ADDR_DIV:    div_d            = DIV_W'(data_in);
`ifdef DAC_IRQ_EN
        ADDR_CTRL:   ie_d             = data_in[CTRL_IE_BIT];
`endif
        default: ;
      endcase
    end
    if (wr_ctrl && data_in[CTRL_CLR_BIT]) done_d = 1'b0;
    if (frame_end)                        done_d = 1'b1;
  end

  // Read mux; data_out only updates on a bus cycle
  always_comb begin
    cha_ext = 16'(cha_q);
    chb_ext = 16'(chb_q);
    case (addr)
      ADDR_CHA_LO: rd_data = cha_ext[7:0];
      ADDR_CHA_HI: rd_data = cha_ext[15:8];
      ADDR_CHB_LO: rd_data = chb_ext[7:0];
      ADDR_CHB_HI: rd_data = chb_ext[15:8];
      ADDR_DIV:    rd_data = 8'(div_q);
      ADDR_CTRL:   rd_data = status_byte(done_q, ie_q, busy);
      default:     rd_data = RD_UNMAPPED;
    endcase
    data_out_d = bus_cyc ? rd_data : data_out_q;
  end

  // Bus-side registers
  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      cha_q      <= '0;
      chb_q      <= '0;
      div_q      <= '0;
      ie_q       <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      cha_q      <= cha_d;
      chb_q      <= chb_d;
      div_q      <= div_d;
      ie_q       <= ie_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
    end
  end

  // FSM state register
  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: each non-idle state lasts one timer period
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc) state_d = ST_LOW;
      ST_LOW:   if (tick)      state_d = ST_HIGH;
      ST_HIGH:  if (tick)      state_d = (bitcnt_q != '0) ? ST_LOW : ST_LATCH;
      ST_LATCH: if (tick)      state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Frame datapath: snapshot on START, shift on the falling dac_clk edge
  always_comb begin
    sha_d      = sha_q;
    shb_d      = shb_q;
    bitcnt_d   = bitcnt_q;
    div_snap_d = div_snap_q;
    if (start_acc) begin
      sha_d      = cha_q;
      shb_d      = chb_q;
      bitcnt_d   = CNT_W'(WIDTH - 1);
      div_snap_d = div_q;
    end else if ((state_q == ST_HIGH) && tick && (bitcnt_q != '0)) begin
      sha_d    = {sha_q[WIDTH-2:0], 1'b0};
      shb_d    = {shb_q[WIDTH-2:0], 1'b0};
      bitcnt_d = bitcnt_q - 1'b1;
    end
  end

  // Frame datapath registers
  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      sha_q      <= '0;
      shb_q      <= '0;
      bitcnt_q   <= '0;
      div_snap_q <= '0;
    end else begin
      sha_q      <= sha_d;
      shb_q      <= shb_d;
      bitcnt_q   <= bitcnt_d;
      div_snap_q <= div_snap_d;
    end
  end

  // FSM outputs, decoded from flops so reset forces them low at once
  always_comb begin
    dac_clk  = (state_q == ST_HIGH);
    dac_le   = (state_q == ST_LATCH);
    dac_dat0 = busy & sha_q[WIDTH-1];
    dac_dat1 = busy & shb_q[WIDTH-1];
  end

  assign data_out = data_out_q;

`ifdef DAC_IRQ_EN
  assign irq = done_q & ie_q;
`endif

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx: register map, frame shape/timing,
// busy-time write isolation, and asynchronous reset mid-frame.
module tb_dac_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       bus_cyc, bus_we;
  logic       dac_clk, dac_le, dac_dat0, dac_dat1;
`ifdef DAC_IRQ_EN
  logic       irq;
`endif

  always #5 clk = ~clk;

  dac_serial_tx #(
    .WIDTH (12),
    .DIV_W (8)
  ) dut (
    .wb_clk_i (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .bus_cyc  (bus_cyc),
    .bus_we   (bus_we),
    .dac_clk  (dac_clk),
    .dac_le   (dac_le),
    .dac_dat0 (dac_dat0),
    .dac_dat1 (dac_dat1)
`ifdef DAC_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Pin monitor: samples on the falling edge, tracks level run lengths,
  // captures the data bits present at each rising dac_clk.
  int          cyc_cnt     = 0;
  int          last_chg    = 0;
  int          start_idx   = 0;
  int          h_exp       = 1;
  int          bad_runs    = 0;
  int          rises       = 0;
  int          le_pulses   = 0;
  int          le_fall_idx = 0;
  logic [1:0]  prev_ph     = 2'b00;
  logic [11:0] rx0         = '0;
  logic [11:0] rx1         = '0;

  always @(negedge clk) begin : mon
    logic [1:0] ph;
    int now, ref_idx;
    now = cyc_cnt + 1;
    ph  = {dac_le, dac_clk};
    cyc_cnt <= now;
    if (!rst && (ph != prev_ph)) begin
      ref_idx = (last_chg > start_idx) ? last_chg : start_idx;
      if (now - ref_idx != h_exp) bad_runs <= bad_runs + 1;
      last_chg <= now;
      if (prev_ph == 2'b00 && ph == 2'b01) begin
        rises <= rises + 1;
        rx0   <= {rx0[10:0], dac_dat0};
        rx1   <= {rx1[10:0], dac_dat1};
      end
      if (ph == 2'b10) le_pulses <= le_pulses + 1;
      if (prev_ph == 2'b10 && ph == 2'b00) le_fall_idx <= now;
    end
    prev_ph <= ph;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_cyc = 1'b1; bus_we = 1'b1; addr = a; data_in = d;
    @(posedge clk);
    #1;
    bus_cyc = 1'b0; bus_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    @(negedge clk);
    bus_cyc = 1'b1; bus_we = 1'b0; addr = a;
    @(posedge clk);
    #1;
    bus_cyc = 1'b0;
    v = data_out;
  endtask

  int base_rises, base_le, base_bad;

  task automatic start_frame();
    wr(4'h5, 8'h01);
    start_idx  = cyc_cnt + 1;
    base_rises = rises;
    base_le    = le_pulses;
    base_bad   = bad_runs;
  endtask

  task automatic wait_frame(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (le_fall_idx > start_idx) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic [7:0] v;
  logic       ok;
  logic       saw_high;

  initial begin
    rst = 1'b1; bus_cyc = 1'b0; bus_we = 1'b0; addr = '0; data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_pins", {dac_clk, dac_le, dac_dat0, dac_dat1}, 4'b0000);
    rst = 1'b0;
    rd(4'h5, v);
    chk("rst_status", v, 8'h00);

    // CHA=0xABC, CHB=0x123, DIV=0: 12 bits each, 25-clock frame
    wr(4'h0, 8'hBC); wr(4'h1, 8'h0A); wr(4'h2, 8'h23); wr(4'h3, 8'h01); wr(4'h4, 8'h00);
    h_exp = 1;
    start_frame();
    wait_frame(200, ok);
    chk("f0_done", ok, 1'b1);
    chk("f0_len", le_fall_idx - start_idx, 25);
    chk("f0_rises", rises - base_rises, 12);
    chk("f0_dat0", rx0, 12'hABC);
    chk("f0_dat1", rx1, 12'h123);
    chk("f0_le_pulses", le_pulses - base_le, 1);
    chk("f0_run_len", bad_runs - base_bad, 0);
    chk("f0_idle_pins", {dac_clk, dac_le, dac_dat0, dac_dat1}, 4'b0000);

    // Status/register map
    rd(4'h5, v);  chk("stat_done", v, 8'h80);
    wr(4'h5, 8'h80);
    rd(4'h5, v);  chk("stat_clr", v, 8'h00);
    rd(4'hF, v);  chk("unmapped", v, 8'hAA);
    rd(4'h1, v);  chk("cha_hi", v, 8'h0A);
    wr(4'h3, 8'hFF);
    rd(4'h3, v);  chk("chb_hi_mask", v, 8'h0F);
    wr(4'h3, 8'h01);

    // DIV=4: every level 5 clocks, frame 125 clocks
    wr(4'h4, 8'h04);
    h_exp = 5;
    start_frame();
    rd(4'h5, v);  chk("stat_busy", v, 8'h01);
    wait_frame(400, ok);
    chk("f1_done", ok, 1'b1);
    chk("f1_len", le_fall_idx - start_idx, 125);
    chk("f1_run_len", bad_runs - base_bad, 0);
    chk("f1_rises", rises - base_rises, 12);
    chk("f1_dat0", rx0, 12'hABC);

    // Writes and START while busy must not disturb the running frame
    wr(4'h0, 8'hF0); wr(4'h1, 8'h00); wr(4'h2, 8'hFF); wr(4'h3, 8'h0F); wr(4'h4, 8'h01);
    h_exp = 2;
    start_frame();
    wr(4'h0, 8'h33); wr(4'h1, 8'h03); wr(4'h4, 8'h07); wr(4'h5, 8'h01);
    wait_frame(300, ok);
    chk("f2_done", ok, 1'b1);
    repeat (60) @(negedge clk);
    chk("f2_len", le_fall_idx - start_idx, 50);
    chk("f2_le_pulses", le_pulses - base_le, 1);
    chk("f2_dat0", rx0, 12'h0F0);
    chk("f2_dat1", rx1, 12'hFFF);
    chk("f2_run_len", bad_runs - base_bad, 0);

    // Next START picks up the new CHA (DIV written as 7 mid-frame -> H=8)
    h_exp = 8;
    start_frame();
    wait_frame(600, ok);
    chk("f3_done", ok, 1'b1);
    chk("f3_len", le_fall_idx - start_idx, 200);
    chk("f3_dat0", rx0, 12'h333);
    chk("f3_dat1", rx1, 12'hFFF);

`ifdef DAC_IRQ_EN
    chk("irq_ie0", irq, 1'b0);
    wr(4'h5, 8'h02);
    chk("irq_set", irq, 1'b1);
    rd(4'h5, v);  chk("stat_ie", v, 8'h82);
    wr(4'h5, 8'h82);
    chk("irq_clr", irq, 1'b0);
    wr(4'h5, 8'h00);
`else
    wr(4'h5, 8'h02);
    rd(4'h5, v);  chk("stat_ie_ignored", v, 8'h80);
`endif

    // Asynchronous reset during a HIGH phase
    wr(4'h1, 8'h08);
    wr(4'h4, 8'h03);
    h_exp = 4;
    start_frame();
    saw_high = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dac_clk) begin
        saw_high = 1'b1;
        break;
      end
    end
    chk("rst_saw_high", saw_high, 1'b1);
    chk("rst_pre_dat", {dac_dat0, dac_dat1}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_pins", {dac_clk, dac_le, dac_dat0, dac_dat1}, 4'b0000);
    chk("rst_mid_data_out", data_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    rd(4'h5, v);  chk("rst_mid_status", v, 8'h00);
    rd(4'h0, v);  chk("rst_mid_cha", v, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
